multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath. Sequences each instruction through
//  fetch/decode/execute/memory/writeback, driving datapath muxes, register/memory enables and
//  the 2-bit ALUOp consumed by the ALU control decoder. Stalls on a memory ready handshake.
// PARAMETERS
//  OP_RTYPE  6'b000000  R-type opcode (ALU function selected by funct downstream)
//  OP_LW     6'b100011  load word opcode
//  OP_SW     6'b101011  store word opcode
//  OP_BEQ    6'b000100  branch-if-equal opcode
//  OP_J      6'b000010  jump opcode
//  OP_ADDI   6'b001000  add-immediate opcode (decoded only with ADDI_EN)
// PORTS
//  clk            in   1  rising-edge clock (single clock domain)
//  rst_n          in   1  synchronous active-low reset
//  opcode         in   6  IR[31:26], valid from DECODE onward
//  mem_ready      in   1  memory completes the current read/write this cycle
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load if ALU zero
//  iord           out  1  memory address: 0=PC, 1=ALUOut
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  IR load
//  mem_to_reg     out  1  regfile write data: 0=ALUOut, 1=MDR
//  reg_dst        out  1  regfile dest: 0=rt, 1=rd
//  reg_write      out  1  regfile write enable
//  alu_src_a      out  1  0=PC, 1=A
//  alu_src_b      out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  alu_op         out  2  00=add, 01=subtract, 10=use funct
//  pc_source      out  2  00=ALU result, 01=ALUOut, 10=jump target
//  illegal_op     out  1  unsupported opcode seen in DECODE
//  state          out  4  current state encoding (debug)
// BEHAVIOUR
//  - State register only sequential element; outputs are decodes of state (+ mem_ready/opcode where noted).
//  - Encoding: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 RWB=7 BRANCH=8 JUMP=9
//    ADDI_EX=10 ADDI_WB=11; codes 12-15 unreachable, recover to FETCH next cycle with all outputs 0.
//  - rst_n=0 at a clock edge: state<=FETCH, overriding any transition (incl. mid-MEMRD/MEMWR).
//    While rst_n=0 every output is forced 0 (combinational gate); state reads 0.
//  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00;
//    ir_write=pc_write=mem_ready. mem_ready=0 -> stay FETCH; 1 -> DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next: LW/SW->MEMADR, RTYPE->EXEC,
//    BEQ->BRANCH, J->JUMP, ADDI->ADDI_EX (macro only); any other -> FETCH with illegal_op=1 this cycle only.
//  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; LW->MEMRD, SW->MEMWR (opcode held stable by IR).
//  - MEMRD: mem_read=1, iord=1; hold until mem_ready=1, then MEMWB.
//  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; -> FETCH.
//  - MEMWR: mem_write=1, iord=1; hold until mem_ready=1, then FETCH.
//  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; -> RWB. RWB: reg_write=1, reg_dst=1, mem_to_reg=0; -> FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1; -> FETCH.
//  - JUMP: pc_write=1, pc_source=10; -> FETCH.
//  - Unlisted outputs are 0 in each state. mem_read and mem_write never both 1.
//  - Cycle counts (mem_ready=1): LW 5, SW 4, R-type 4, BEQ 3, J 3, ADDI 4.
// CONFIGURATION
//  ADDI_EN defined: OP_ADDI in DECODE -> ADDI_EX (alu_src_a=1, alu_src_b=10, alu_op=00) -> ADDI_WB
//    (reg_write=1, reg_dst=0, mem_to_reg=0) -> FETCH.
//  ADDI_EN undefined: states 10/11 not built; OP_ADDI treated as illegal (illegal_op=1, -> FETCH).
// TESTING
//  1 LW, mem_ready low 2 cycles in FETCH and 1 in MEMRD -> states 0,0,0,1,2,3,3,4,0; ir_write 1 only on 3rd FETCH cycle.
//  2 R-type (opcode 0), mem_ready=1 -> states 0,1,6,7; alu_op=10 in EXEC; reg_write=1,reg_dst=1 in RWB.
//  3 BEQ (000100) -> states 0,1,8; alu_op=01, pc_source=01, pc_write_cond=1 in BRANCH; J -> state 9, pc_source=10, pc_write=1.
//  4 SW -> 0,1,2,5 with mem_write=1,iord=1 in MEMWR; opcode 6'b111111 -> illegal_op=1 in DECODE, next state 0.
//  5 rst_n=0 for one edge while in MEMRD -> state 0 next cycle; all outputs 0 during rst_n=0.
//  6 Opcode 001000: with ADDI_EN -> 0,1,10,11, reg_write=1 in ADDI_WB; without -> illegal_op=1, back to 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle MIPS control FSM.
// The master modport is the controller side; the slave modport is the datapath side.
interface multicycle_control_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write;
   logic       pc_write_cond;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;
   logic       illegal_op;
   logic [3:0] state;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, state
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, state
   );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Optional macro ADDI_EN adds the ADDI_EX/ADDI_WB states; without it ADDI decodes as illegal.
module multicycle_control #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_J     = 6'b000010,
   parameter logic [5:0] OP_ADDI  = 6'b001000
) (
   input logic                 clk,
   input logic                 rst_n,
   multicycle_control_if.master bus
);

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_EXEC    = 4'd6;
   localparam logic [3:0] S_RWB     = 4'd7;
   localparam logic [3:0] S_BRANCH  = 4'd8;
   localparam logic [3:0] S_JUMP    = 4'd9;
   localparam logic [3:0] S_ADDI_EX = 4'd10;
   localparam logic [3:0] S_ADDI_WB = 4'd11;

   logic [3:0] state_r;
   logic [3:0] next_state_s;
   logic       pc_write_s;
   logic       pc_write_cond_s;
   logic       iord_s;
   logic       mem_read_s;
   logic       mem_write_s;
   logic       ir_write_s;
   logic       mem_to_reg_s;
   logic       reg_dst_s;
   logic       reg_write_s;
   logic       alu_src_a_s;
   logic [1:0] alu_src_b_s;
   logic [1:0] alu_op_s;
   logic [1:0] pc_source_s;
   logic       illegal_op_s;

   // State register; reset wins over any pending transition, including memory waits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and control decode; unused/unbuilt codes fall back to FETCH with all controls low.
   always_comb begin
      next_state_s    = S_FETCH;
      pc_write_s      = 1'b0;
      pc_write_cond_s = 1'b0;
      iord_s          = 1'b0;
      mem_read_s      = 1'b0;
      mem_write_s     = 1'b0;
      ir_write_s      = 1'b0;
      mem_to_reg_s    = 1'b0;
      reg_dst_s       = 1'b0;
      reg_write_s     = 1'b0;
      alu_src_a_s     = 1'b0;
      alu_src_b_s     = 2'b00;
      alu_op_s        = 2'b00;
      pc_source_s     = 2'b00;
      illegal_op_s    = 1'b0;
      case (state_r)
         S_FETCH: begin
            mem_read_s  = 1'b1;
            alu_src_b_s = 2'b01;
            ir_write_s  = bus.mem_ready;
            pc_write_s  = bus.mem_ready;
            if (bus.mem_ready) begin
               next_state_s = S_DECODE;
            end else begin
               next_state_s = S_FETCH;
            end
         end
         S_DECODE: begin
            alu_src_b_s = 2'b11;
            case (bus.opcode)
               OP_LW, OP_SW: next_state_s = S_MEMADR;
               OP_RTYPE:     next_state_s = S_EXEC;
               OP_BEQ:       next_state_s = S_BRANCH;
               OP_J:         next_state_s = S_JUMP;
`ifdef ADDI_EN
               OP_ADDI:      next_state_s = S_ADDI_EX;
`else
               OP_ADDI: begin
                  illegal_op_s = 1'b1;
                  next_state_s = S_FETCH;
               end
`endif
               default: begin
                  illegal_op_s = 1'b1;
                  next_state_s = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = 2'b10;
            if (bus.opcode == OP_LW) begin
               next_state_s = S_MEMRD;
            end else if (bus.opcode == OP_SW) begin
               next_state_s = S_MEMWR;
            end else begin
               next_state_s = S_FETCH;
            end
         end
         S_MEMRD: begin
            mem_read_s = 1'b1;
            iord_s     = 1'b1;
            if (bus.mem_ready) begin
               next_state_s = S_MEMWB;
            end else begin
               next_state_s = S_MEMRD;
            end
         end
         S_MEMWB: begin
            reg_write_s  = 1'b1;
            mem_to_reg_s = 1'b1;
            next_state_s = S_FETCH;
         end
         S_MEMWR: begin
            mem_write_s = 1'b1;
            iord_s      = 1'b1;
            if (bus.mem_ready) begin
               next_state_s = S_FETCH;
            end else begin
               next_state_s = S_MEMWR;
            end
         end
         S_EXEC: begin
            alu_src_a_s  = 1'b1;
            alu_op_s     = 2'b10;
            next_state_s = S_RWB;
         end
         S_RWB: begin
            reg_write_s  = 1'b1;
            reg_dst_s    = 1'b1;
            next_state_s = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_s     = 1'b1;
            alu_op_s        = 2'b01;
            pc_source_s     = 2'b01;
            pc_write_cond_s = 1'b1;
            next_state_s    = S_FETCH;
         end
         S_JUMP: begin
            pc_write_s   = 1'b1;
            pc_source_s  = 2'b10;
            next_state_s = S_FETCH;
         end
`ifdef ADDI_EN
         S_ADDI_EX: begin
            alu_src_a_s  = 1'b1;
            alu_src_b_s  = 2'b10;
            next_state_s = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            reg_write_s  = 1'b1;
            next_state_s = S_FETCH;
         end
`endif
         default: begin
            next_state_s = S_FETCH;
         end
      endcase
   end

   // While reset is asserted every control line and the debug state read as zero.
   assign bus.pc_write      = rst_n & pc_write_s;
   assign bus.pc_write_cond = rst_n & pc_write_cond_s;
   assign bus.iord          = rst_n & iord_s;
   assign bus.mem_read      = rst_n & mem_read_s;
   assign bus.mem_write     = rst_n & mem_write_s;
   assign bus.ir_write      = rst_n & ir_write_s;
   assign bus.mem_to_reg    = rst_n & mem_to_reg_s;
   assign bus.reg_dst       = rst_n & reg_dst_s;
   assign bus.reg_write     = rst_n & reg_write_s;
   assign bus.alu_src_a     = rst_n & alu_src_a_s;
   assign bus.alu_src_b     = rst_n ? alu_src_b_s : 2'b00;
   assign bus.alu_op        = rst_n ? alu_op_s    : 2'b00;
   assign bus.pc_source     = rst_n ? pc_source_s : 2'b00;
   assign bus.illegal_op    = rst_n & illegal_op_s;
   assign bus.state         = rst_n ? state_r     : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state/controls are queued
// as stimulus is applied and compared against the DUT between clock edges.
module tb_multicycle_control;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BAD   = 6'b111111;

   typedef struct packed {
      logic [3:0]  st;
      logic [16:0] outs;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_failed;
   exp_t sb_q[$];

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected control vector per state, straight from the state/output table.
   function automatic logic [16:0] exp_outs(input logic [3:0] st, input logic [5:0] op,
                                            input logic mr, input logic rn);
      logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill;
      logic [1:0] asb, aop, psrc;
      {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill} = 11'b0;
      {asb, aop, psrc} = 6'b0;
      case (st)
         4'd0: begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
         4'd1: begin
            asb = 2'b11;
            ill = !(op == OP_LW || op == OP_SW || op == OP_RTYPE || op == OP_BEQ || op == OP_J
`ifdef ADDI_EN
                    || op == OP_ADDI
`endif
                   );
         end
         4'd2:  begin asa = 1'b1; asb = 2'b10; end
         4'd3:  begin mrd = 1'b1; iord = 1'b1; end
         4'd4:  begin rw = 1'b1; m2r = 1'b1; end
         4'd5:  begin mwr = 1'b1; iord = 1'b1; end
         4'd6:  begin asa = 1'b1; aop = 2'b10; end
         4'd7:  begin rw = 1'b1; rdst = 1'b1; end
         4'd8:  begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pcwc = 1'b1; end
         4'd9:  begin pcw = 1'b1; psrc = 2'b10; end
         4'd10: begin asa = 1'b1; asb = 2'b10; end
         4'd11: begin rw = 1'b1; end
         default: ;
      endcase
      if (!rn) return 17'b0;
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill};
   endfunction

   // One clock cycle: drive inputs, queue the expectation, compare mid-cycle.
   task automatic step(input logic rn, input logic [5:0] op, input logic mr,
                       input logic [3:0] exp_st, input string tag);
      exp_t e;
      exp_t got;
      @(negedge clk);
      rst_n         = rn;
      bus.opcode    = op;
      bus.mem_ready = mr;
      sb_q.push_back('{st: exp_st, outs: exp_outs(exp_st, op, mr, rn)});
      #1;
      got.st   = bus.state;
      got.outs = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                  bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                  bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op};
      if (sb_q.size() == 0) begin
         check_eq({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check_eq({tag, "_state"}, {28'd0, got.st}, {28'd0, e.st});
         check_eq({tag, "_outs"}, {15'd0, got.outs}, {15'd0, e.outs});
         if (bus.mem_read && bus.mem_write) begin
            check_eq({tag, "_rd_wr_excl"}, 32'd1, 32'd0);
         end else begin
            check_eq({tag, "_rd_wr_excl"}, 32'd0, 32'd0);
         end
      end
   endtask

   initial begin
      n_tests       = 0;
      n_failed      = 0;
      rst_n         = 1'b0;
      bus.opcode    = 6'd0;
      bus.mem_ready = 1'b0;

      step(1'b0, OP_LW, 1'b1, 4'd0, "reset0");
      step(1'b0, OP_LW, 1'b1, 4'd0, "reset1");

      // LW with fetch and memory-read stalls.
      step(1'b1, OP_LW, 1'b0, 4'd0, "lw_f0");
      step(1'b1, OP_LW, 1'b0, 4'd0, "lw_f1");
      step(1'b1, OP_LW, 1'b1, 4'd0, "lw_f2");
      step(1'b1, OP_LW, 1'b1, 4'd1, "lw_dec");
      step(1'b1, OP_LW, 1'b1, 4'd2, "lw_adr");
      step(1'b1, OP_LW, 1'b0, 4'd3, "lw_rd0");
      step(1'b1, OP_LW, 1'b1, 4'd3, "lw_rd1");
      step(1'b1, OP_LW, 1'b1, 4'd4, "lw_wb");

      // R-type.
      step(1'b1, OP_RTYPE, 1'b1, 4'd0, "r_f");
      step(1'b1, OP_RTYPE, 1'b1, 4'd1, "r_dec");
      step(1'b1, OP_RTYPE, 1'b1, 4'd6, "r_ex");
      step(1'b1, OP_RTYPE, 1'b1, 4'd7, "r_wb");

      // BEQ then J.
      step(1'b1, OP_BEQ, 1'b1, 4'd0, "beq_f");
      step(1'b1, OP_BEQ, 1'b1, 4'd1, "beq_dec");
      step(1'b1, OP_BEQ, 1'b1, 4'd8, "beq_br");
      step(1'b1, OP_J, 1'b1, 4'd0, "j_f");
      step(1'b1, OP_J, 1'b1, 4'd1, "j_dec");
      step(1'b1, OP_J, 1'b1, 4'd9, "j_jmp");

      // SW with one write stall, then an illegal opcode.
      step(1'b1, OP_SW, 1'b1, 4'd0, "sw_f");
      step(1'b1, OP_SW, 1'b1, 4'd1, "sw_dec");
      step(1'b1, OP_SW, 1'b1, 4'd2, "sw_adr");
      step(1'b1, OP_SW, 1'b0, 4'd5, "sw_wr0");
      step(1'b1, OP_SW, 1'b1, 4'd5, "sw_wr1");
      step(1'b1, OP_BAD, 1'b1, 4'd0, "bad_f");
      step(1'b1, OP_BAD, 1'b1, 4'd1, "bad_dec");

      // Reset asserted while stalled in MEMRD.
      step(1'b1, OP_LW, 1'b1, 4'd0, "rst_f");
      step(1'b1, OP_LW, 1'b1, 4'd1, "rst_dec");
      step(1'b1, OP_LW, 1'b1, 4'd2, "rst_adr");
      step(1'b1, OP_LW, 1'b0, 4'd3, "rst_rd");
      step(1'b0, OP_LW, 1'b1, 4'd0, "rst_low");
      step(1'b1, OP_LW, 1'b0, 4'd0, "rst_after");

      // ADDI: built feature or illegal opcode.
      step(1'b1, OP_ADDI, 1'b1, 4'd0, "addi_f");
      step(1'b1, OP_ADDI, 1'b1, 4'd1, "addi_dec");
`ifdef ADDI_EN
      step(1'b1, OP_ADDI, 1'b1, 4'd10, "addi_ex");
      step(1'b1, OP_ADDI, 1'b1, 4'd11, "addi_wb");
`endif
      step(1'b1, OP_RTYPE, 1'b0, 4'd0, "final_f");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
